// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive paths.
package uart_pkg;

    localparam int DATA_BITS = 8;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = S_IDLE,
        START  = S_START,
        DATA   = S_DATA,
        PARITY = S_PARITY,
        STOP   = S_STOP
    } uart_state_t;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period counter; tick marks the last clock of each serial bit.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int W = $clog2(CLKS_PER_BIT);
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB-first, optional parity, stop bit(s).
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy
);

    logic [2:0] state;
    logic [7:0] shift;
    logic [2:0] bit_idx;
    logic       stop_cnt;
    logic       par_bit;
    logic       tick;
    logic       accept;

    assign tx_ready = (state == S_IDLE);
    assign busy     = ~tx_ready;
    assign accept   = tx_valid && tx_ready;

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .restart(accept),
        .tick   (tick)
    );

    // tx is loaded with the value of the bit being entered, so it stays a flop output
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            shift    <= '0;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
            par_bit  <= 1'b0;
            tx       <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    tx <= 1'b1;
                    if (accept) begin
                        state    <= S_START;
                        shift    <= tx_data;
                        bit_idx  <= '0;
                        stop_cnt <= 1'b0;
                        par_bit  <= (^tx_data) ^ (PARITY == PAR_ODD);
                        tx       <= 1'b0;
                    end
                end
                S_START: begin
                    if (tick) begin
                        state <= S_DATA;
                        tx    <= shift[0];
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        shift   <= shift >> 1;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'(DATA_BITS - 1)) begin
                            if (PARITY != PAR_NONE) begin
                                state <= S_PARITY;
                                tx    <= par_bit;
                            end else begin
                                state <= S_STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            tx <= shift[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (tick) begin
                        state <= S_STOP;
                        tx    <= 1'b1;
                    end
                end
                S_STOP: begin
                    tx <= 1'b1;
                    if (tick) begin
                        if (STOP_BITS == 2 && !stop_cnt) begin
                            stop_cnt <= 1'b1;
                        end else begin
                            stop_cnt <= 1'b0;
                            state    <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx across several parameter sets.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic       valid;
    int         sel;

    logic valid_w [5];
    logic tx_w    [5];
    logic rdy_w   [5];
    logic busy_w  [5];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < 5; k++) begin
            valid_w[k] = valid && (sel == k);
        end
    end

    uart_tx #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst), .tx_data(data), .tx_valid(valid_w[0]),
        .tx_ready(rdy_w[0]), .tx(tx_w[0]), .busy(busy_w[0]));
    uart_tx #(.CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) u1 (
        .clk(clk), .rst(rst), .tx_data(data), .tx_valid(valid_w[1]),
        .tx_ready(rdy_w[1]), .tx(tx_w[1]), .busy(busy_w[1]));
    uart_tx #(.CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1)) u2 (
        .clk(clk), .rst(rst), .tx_data(data), .tx_valid(valid_w[2]),
        .tx_ready(rdy_w[2]), .tx(tx_w[2]), .busy(busy_w[2]));
    uart_tx #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(2)) u3 (
        .clk(clk), .rst(rst), .tx_data(data), .tx_valid(valid_w[3]),
        .tx_ready(rdy_w[3]), .tx(tx_w[3]), .busy(busy_w[3]));
    uart_tx u4 (
        .clk(clk), .rst(rst), .tx_data(data), .tx_valid(valid_w[4]),
        .tx_ready(rdy_w[4]), .tx(tx_w[4]), .busy(busy_w[4]));

    function automatic int cpb_of(input int s);
        return (s == 4) ? 434 : 4;
    endfunction

    function automatic int par_of(input int s);
        return (s == 1) ? 1 : (s == 2) ? 2 : 0;
    endfunction

    function automatic int stops_of(input int s);
        return (s == 3) ? 2 : 1;
    endfunction

    // Present a byte and return just after the accepting edge.
    task automatic send(input logic [7:0] b, input bit hold);
        int n = 0;
        @(negedge clk);
        data  = b;
        valid = 1'b1;
        while (rdy_w[sel] !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rdy_w[sel] !== 1'b1) begin
            errors++;
            $display("FAIL handshake sel=%0d ready=%b expected 1", sel, rdy_w[sel]);
        end
        @(posedge clk);
        #1;
        if (!hold) valid = 1'b0;
        data = 8'($urandom);
    endtask

    // Reference line waveform built from the frame rules, one sample per clock.
    task automatic expect_frame(input logic [7:0] b, input string nm);
        int   cpb = cpb_of(sel);
        int   par = par_of(sel);
        int   st  = stops_of(sel);
        logic bits [$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
        if (par != 0) begin
            bits.push_back(logic'(($countones(b) % 2) == 1) ^ logic'(par == 2));
        end
        for (int i = 0; i < st; i++) bits.push_back(1'b1);
        foreach (bits[i]) begin
            for (int c = 0; c < cpb; c++) begin
                @(negedge clk);
                checks++;
                if (tx_w[sel] !== bits[i] || rdy_w[sel] !== 1'b0 || busy_w[sel] !== 1'b1) begin
                    errors++;
                    $display("FAIL %s byte=%02h bit=%0d clk=%0d tx=%b ready=%b busy=%b expected tx=%b ready=0 busy=1",
                             nm, b, i, c, tx_w[sel], rdy_w[sel], busy_w[sel], bits[i]);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (tx_w[sel] !== 1'b1 || rdy_w[sel] !== 1'b1 || busy_w[sel] !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle byte=%02h tx=%b ready=%b busy=%b expected tx=1 ready=1 busy=0",
                     nm, b, tx_w[sel], rdy_w[sel], busy_w[sel]);
        end
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        valid = 1'b0;
        data  = 8'h00;
        sel   = 0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (tx_w[k] !== 1'b1 || rdy_w[k] !== 1'b1 || busy_w[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset dut=%0d tx=%b ready=%b busy=%b expected tx=1 ready=1 busy=0",
                         k, tx_w[k], rdy_w[k], busy_w[k]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        sel = 0;
        send(8'hA5, 1'b0);
        expect_frame(8'hA5, "basic_a5");
    endtask

    task automatic test_parity;
        sel = 1;
        send(8'h07, 1'b0);
        expect_frame(8'h07, "even_parity");
        sel = 2;
        send(8'h07, 1'b0);
        expect_frame(8'h07, "odd_parity");
        sel = 1;
        send(8'hC3, 1'b0);
        expect_frame(8'hC3, "even_parity_c3");
    endtask

    task automatic test_two_stop;
        sel = 3;
        send(8'hFF, 1'b0);
        expect_frame(8'hFF, "two_stop");
    endtask

    task automatic test_back_to_back;
        sel = 0;
        send(8'h55, 1'b1);
        data = 8'hAA;
        expect_frame(8'h55, "b2b_first");
        @(posedge clk);
        #1;
        data  = 8'h0F;
        valid = 1'b0;
        expect_frame(8'hAA, "b2b_second");
    endtask

    task automatic test_reset_mid_frame;
        sel = 0;
        send(8'h96, 1'b0);
        repeat (17) @(negedge clk);
        checks++;
        if (tx_w[0] !== 1'b0) begin
            errors++;
            $display("FAIL mid_bit3 tx=%b expected 0", tx_w[0]);
        end
        rst   = 1'b1;
        valid = 1'b1;
        data  = 8'h5A;
        @(negedge clk);
        checks++;
        if (tx_w[0] !== 1'b1 || rdy_w[0] !== 1'b1 || busy_w[0] !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset tx=%b ready=%b busy=%b expected tx=1 ready=1 busy=0",
                     tx_w[0], rdy_w[0], busy_w[0]);
        end
        rst   = 1'b0;
        valid = 1'b0;
        @(negedge clk);
        checks++;
        if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_wins tx=%b busy=%b expected tx=1 busy=0", tx_w[0], busy_w[0]);
        end
        send(8'h3C, 1'b0);
        expect_frame(8'h3C, "after_reset");
    endtask

    task automatic test_random;
        logic [7:0] b;
        int         gap;
        sel = 0;
        for (int n = 0; n < 256; n++) begin
            b   = 8'($urandom);
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
            send(b, 1'b0);
            expect_frame(b, "random");
        end
    endtask

    task automatic test_default_rate;
        sel = 4;
        send(8'hA5, 1'b0);
        expect_frame(8'hA5, "rate_434");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_two_stop();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        test_default_rate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
